sd_cmd_ctrl: RTL and testbench

SD_CMD_CTRL -- requirements
Module: sd_cmd_ctrl

---
 rtl/sd_pkg.sv | 51 +++++
 rtl/sd_crc7.sv | 52 +++++
 rtl/sd_cmd_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_sd_cmd_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI-mode command controller: FSM encoding,
// frame constants, request payload and frame byte selection.
package sd_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CMD_IDX_W   = 6;
    localparam int unsigned CMD_ARG_W   = 32;
    localparam int unsigned CRC_W       = 7;
    localparam int unsigned FRAME_BYTES = 6;
    localparam int unsigned BCNT_W      = 3;
    localparam int unsigned PCNT_W      = 8;

    localparam logic [BYTE_W-1:0] POLL_BYTE  = 8'hFF;
    localparam logic [1:0]        START_BITS = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    typedef struct packed {
        logic [CMD_IDX_W-1:0] index;
        logic [CMD_ARG_W-1:0] arg;
        logic [CRC_W-1:0]     crc;
    } cmd_req_t;

    // Byte idx of the 6-byte command frame; crc is supplied separately so the
    // caller can choose between the requested and a computed CRC7.
    function automatic logic [BYTE_W-1:0] frame_byte(
        input cmd_req_t          req,
        input logic [BCNT_W-1:0] idx,
        input logic [CRC_W-1:0]  crc
    );
        logic [BYTE_W-1:0] b;
        case (idx)
            3'd0:    b = {START_BITS, req.index};
            3'd1:    b = req.arg[31:24];
            3'd2:    b = req.arg[23:16];
            3'd3:    b = req.arg[15:8];
            3'd4:    b = req.arg[7:0];
            3'd5:    b = {crc, 1'b1};
            default: b = POLL_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Byte-wide CRC7 (x^7 + x^3 + 1, init 0): combinational byte update, registered
// running value. i_clr restarts the CRC, and may coincide with the first i_en.
module sd_crc7
    import sd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [BYTE_W-1:0] i_data,
    output logic [CRC_W-1:0]  o_crc
);

    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_base;
    logic [CRC_W-1:0] w_crc_nxt;

    function automatic logic [CRC_W-1:0] crc7_byte(
        input logic [CRC_W-1:0]  c_in,
        input logic [BYTE_W-1:0] d
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = c_in;
        for (int i = BYTE_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    always_comb begin
        w_base    = i_clr ? '0 : r_crc;
        w_crc_nxt = crc7_byte(w_base, i_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= '0;
        end else if (i_en) begin
            r_crc <= w_crc_nxt;
        end else if (i_clr) begin
            r_crc <= '0;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD SPI-mode command controller: sends a 6-byte command frame through a byte
// engine, then polls with 0xFF until an R1 byte or timeout. Option: SD_CMD_CRC7_EN.
module sd_cmd_ctrl
    import sd_pkg::*;
#(
    parameter int unsigned        POLL_MAX = 8,
    parameter logic [BYTE_W-1:0]  DIV_SLOW = 8'd200,
    parameter logic [BYTE_W-1:0]  DIV_FAST = 8'd4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_start,
    input  logic [CMD_IDX_W-1:0] cmd_index,
    input  logic [CMD_ARG_W-1:0] cmd_arg,
    input  logic [CRC_W-1:0]     cmd_crc,
    input  logic                 fast_mode,
    output logic                 cmd_busy,
    output logic                 cmd_done,
    output logic [BYTE_W-1:0]    resp_r1,
    output logic                 resp_timeout,
    output logic [BYTE_W-1:0]    spi_clk_div,
    output logic [BYTE_W-1:0]    spi_data_write,
    output logic                 spi_write_en,
    output logic                 spi_read_en,
    input  logic [BYTE_W-1:0]    spi_data_read,
    input  logic                 spi_busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    cmd_req_t            r_req;
    logic [BCNT_W-1:0]   r_byte_cnt;
    logic                r_poll_phase;
    logic [PCNT_W-1:0]   r_poll_cnt;
    logic [BYTE_W-1:0]   r_rx;

    cmd_req_t            w_req_nxt;
    logic [BCNT_W-1:0]   w_byte_cnt_nxt;
    logic                w_poll_phase_nxt;
    logic [PCNT_W-1:0]   w_poll_cnt_nxt;
    logic [BYTE_W-1:0]   w_rx_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [BYTE_W-1:0]   w_resp_nxt;
    logic                w_timeout_nxt;
    logic [BYTE_W-1:0]   w_div_nxt;
    logic [BYTE_W-1:0]   w_data_nxt;
    logic                w_wr_en_nxt;

    logic                w_accept;
    cmd_req_t            w_src_req;
    logic [BCNT_W-1:0]   w_src_idx;
    logic [CRC_W-1:0]    w_frame_crc;
    logic [BYTE_W-1:0]   w_frame_byte;

    assign w_accept = (r_state == ST_IDLE) && cmd_start;

    // Byte 0 is taken straight from the inputs in the acceptance cycle.
    always_comb begin
        w_src_req = r_req;
        w_src_idx = BCNT_W'(r_byte_cnt + 3'd1);
        if (r_state == ST_IDLE) begin
            w_src_req = '{index: cmd_index, arg: cmd_arg, crc: cmd_crc};
            w_src_idx = '0;
        end
        w_frame_byte = frame_byte(w_src_req, w_src_idx, w_frame_crc);
    end

`ifdef SD_CMD_CRC7_EN
    logic w_crc_en;
    logic w_unused_crc;

    assign w_crc_en     = w_accept ||
                          ((r_state == ST_NEXT) && !r_poll_phase &&
                           (r_byte_cnt < BCNT_W'(FRAME_BYTES - 2)));
    assign w_unused_crc = ^{cmd_crc, r_req.crc};

    sd_crc7 u_crc7 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_accept),
        .i_en   (w_crc_en),
        .i_data (w_frame_byte),
        .o_crc  (w_frame_crc)
    );
`else
    assign w_frame_crc = r_req.crc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (cmd_start) w_state_nxt = ST_ISSUE;
            ST_ISSUE:   w_state_nxt = ST_WAIT_HI;
            ST_WAIT_HI: if (spi_busy) w_state_nxt = ST_WAIT_LO;
            ST_WAIT_LO: if (!spi_busy) w_state_nxt = ST_NEXT;
            ST_NEXT: begin
                w_state_nxt = ST_ISSUE;
                if (r_poll_phase && (!r_rx[7] || (r_poll_cnt == PCNT_W'(POLL_MAX)))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath, aligned to w_state_nxt.
    always_comb begin
        w_req_nxt        = r_req;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_poll_phase_nxt = r_poll_phase;
        w_poll_cnt_nxt   = r_poll_cnt;
        w_rx_nxt         = r_rx;
        w_resp_nxt       = resp_r1;
        w_timeout_nxt    = resp_timeout;
        w_div_nxt        = spi_clk_div;
        w_data_nxt       = spi_data_write;
        w_wr_en_nxt      = 1'b0;
        w_busy_nxt       = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
        w_done_nxt       = (w_state_nxt == ST_DONE);

        case (r_state)
            ST_IDLE: begin
                if (cmd_start) begin
                    w_req_nxt        = w_src_req;
                    w_div_nxt        = fast_mode ? DIV_FAST : DIV_SLOW;
                    w_resp_nxt       = POLL_BYTE;
                    w_timeout_nxt    = 1'b0;
                    w_byte_cnt_nxt   = '0;
                    w_poll_phase_nxt = 1'b0;
                    w_poll_cnt_nxt   = '0;
                    w_wr_en_nxt      = 1'b1;
                    w_data_nxt       = w_frame_byte;
                end
            end
            ST_WAIT_LO: begin
                if (!spi_busy) begin
                    w_rx_nxt = spi_data_read;
                end
            end
            ST_NEXT: begin
                if (r_poll_phase) begin
                    if (!r_rx[7]) begin
                        w_resp_nxt    = r_rx;
                        w_timeout_nxt = 1'b0;
                    end else if (r_poll_cnt == PCNT_W'(POLL_MAX)) begin
                        w_resp_nxt    = POLL_BYTE;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_poll_cnt_nxt = PCNT_W'(r_poll_cnt + 8'd1);
                        w_wr_en_nxt    = 1'b1;
                        w_data_nxt     = POLL_BYTE;
                    end
                end else if (r_byte_cnt == BCNT_W'(FRAME_BYTES - 1)) begin
                    // Frame complete: received frame bytes are never examined.
                    w_poll_phase_nxt = 1'b1;
                    w_poll_cnt_nxt   = PCNT_W'(1);
                    w_wr_en_nxt      = 1'b1;
                    w_data_nxt       = POLL_BYTE;
                end else begin
                    w_byte_cnt_nxt = BCNT_W'(r_byte_cnt + 3'd1);
                    w_wr_en_nxt    = 1'b1;
                    w_data_nxt     = w_frame_byte;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req          <= '0;
            r_byte_cnt     <= '0;
            r_poll_phase   <= 1'b0;
            r_poll_cnt     <= '0;
            r_rx           <= POLL_BYTE;
            cmd_busy       <= 1'b0;
            cmd_done       <= 1'b0;
            resp_r1        <= POLL_BYTE;
            resp_timeout   <= 1'b0;
            spi_clk_div    <= DIV_SLOW;
            spi_data_write <= POLL_BYTE;
            spi_write_en   <= 1'b0;
            spi_read_en    <= 1'b0;
        end else begin
            r_req          <= w_req_nxt;
            r_byte_cnt     <= w_byte_cnt_nxt;
            r_poll_phase   <= w_poll_phase_nxt;
            r_poll_cnt     <= w_poll_cnt_nxt;
            r_rx           <= w_rx_nxt;
            cmd_busy       <= w_busy_nxt;
            cmd_done       <= w_done_nxt;
            resp_r1        <= w_resp_nxt;
            resp_timeout   <= w_timeout_nxt;
            spi_clk_div    <= w_div_nxt;
            spi_data_write <= w_data_nxt;
            spi_write_en   <= w_wr_en_nxt;
            spi_read_en    <= w_wr_en_nxt;
        end
    end

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed testbench for sd_cmd_ctrl with a behavioural SPI byte-engine model.
module tb_sd_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic        fast_mode;
    logic        cmd_busy;
    logic        cmd_done;
    logic [7:0]  resp_r1;
    logic        resp_timeout;
    logic [7:0]  spi_clk_div;
    logic [7:0]  spi_data_write;
    logic        spi_write_en;
    logic        spi_read_en;
    logic [7:0]  spi_data_read;
    logic        spi_busy;

    always #5 clk = ~clk;

    sd_cmd_ctrl #(.POLL_MAX(8), .DIV_SLOW(8'd200), .DIV_FAST(8'd4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_start      (cmd_start),
        .cmd_index      (cmd_index),
        .cmd_arg        (cmd_arg),
        .cmd_crc        (cmd_crc),
        .fast_mode      (fast_mode),
        .cmd_busy       (cmd_busy),
        .cmd_done       (cmd_done),
        .resp_r1        (resp_r1),
        .resp_timeout   (resp_timeout),
        .spi_clk_div    (spi_clk_div),
        .spi_data_write (spi_data_write),
        .spi_write_en   (spi_write_en),
        .spi_read_en    (spi_read_en),
        .spi_data_read  (spi_data_read),
        .spi_busy       (spi_busy)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] mosi_q[$];
    logic [7:0] poll_resp[8];
    int         poll_len = 0;
    int         eng_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] done_resp = 8'h00;
    logic       done_to = 1'b0;
    logic       done_busy = 1'b0;
    logic [7:0] exp_div = 8'd200;
    int         div_bad = 0;
    int         rw_bad = 0;

    // Frame-phase bytes come back as 0x00 so a controller that looked at them would stop early.
    function automatic logic [7:0] eng_resp(input int n);
        if (n < 6) return 8'h00;
        if ((n - 6) < poll_len) return poll_resp[n - 6];
        return 8'hFF;
    endfunction

    // Byte engine: busy one cycle after the pulse, data valid when busy falls.
    initial begin
        spi_busy      = 1'b0;
        spi_data_read = 8'hFF;
        forever begin
            @(negedge clk);
            if (spi_write_en !== spi_read_en) rw_bad++;
            if (cmd_done === 1'b1) begin
                done_cnt++;
                done_resp = resp_r1;
                done_to   = resp_timeout;
                done_busy = cmd_busy;
            end
            if (cmd_busy === 1'b1 && spi_clk_div !== exp_div) div_bad++;
            if (rst_n !== 1'b1) begin
                spi_busy = 1'b0;
                eng_cnt  = 0;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    spi_data_read = eng_resp(mosi_q.size() - 1);
                    spi_busy      = 1'b0;
                end
            end else if (spi_write_en === 1'b1) begin
                mosi_q.push_back(spi_data_write);
                spi_busy = 1'b1;
                eng_cnt  = 3;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prep(input logic [7:0] div);
        mosi_q.delete();
        done_cnt = 0;
        div_bad  = 0;
        poll_len = 0;
        exp_div  = div;
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [6:0] crc, input logic fast);
        @(negedge clk);
        cmd_index = idx;
        cmd_arg   = arg;
        cmd_crc   = crc;
        fast_mode = fast;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (done_cnt == 0 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        repeat (40) @(negedge clk);
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    task automatic chk_mosi(input string tag, input logic [7:0] exp[], input int n);
        logic [7:0] v;
        chk({tag, "_len"}, mosi_q.size(), n);
        for (int i = 0; i < n; i++) begin
            v = 8'hxx;
            if (i < mosi_q.size()) v = mosi_q[i];
            chk($sformatf("%s_mosi%0d", tag, i), v, exp[i]);
        end
    endtask

    initial begin
        logic [7:0] exp_cmd0[];
        logic [7:0] exp_to[];
        int         k;

        exp_cmd0 = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        exp_to   = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        rst_n     = 1'b0;
        cmd_start = 1'b0;
        cmd_index = '0;
        cmd_arg   = '0;
        cmd_crc   = '0;
        fast_mode = 1'b0;
        for (int i = 0; i < 8; i++) poll_resp[i] = 8'hFF;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", cmd_busy, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_resp", resp_r1, 8'hFF);
        chk("rst_to", resp_timeout, 0);
        chk("rst_wr", spi_write_en, 0);
        chk("rst_rd", spi_read_en, 0);
        chk("rst_dw", spi_data_write, 8'hFF);
        chk("rst_div", spi_clk_div, 8'd200);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CMD0 with R1 on third poll
        prep(8'd200);
        poll_resp[0] = 8'hFF; poll_resp[1] = 8'hFF; poll_resp[2] = 8'h01; poll_len = 3;
        start_cmd(6'd0, 32'h0, 7'h4A, 1'b0);
        chk("cmd0_busy_after_start", cmd_busy, 1);
        wait_done("cmd0");
        chk_mosi("cmd0", exp_cmd0, 9);
        chk("cmd0_resp", done_resp, 8'h01);
        chk("cmd0_to", done_to, 0);
        chk("cmd0_busy_at_done", done_busy, 0);
        chk("cmd0_div", div_bad, 0);
        chk("cmd0_resp_hold", resp_r1, 8'h01);
        chk("cmd0_idle_busy", cmd_busy, 0);

        // Timeout with fast_mode dropped mid-command
        prep(8'd4);
        start_cmd(6'd0, 32'h0, 7'h4A, 1'b1);
        repeat (20) @(negedge clk);
        fast_mode = 1'b0;
        wait_done("to");
        chk_mosi("to", exp_to, 14);
        chk("to_resp", done_resp, 8'hFF);
        chk("to_flag", done_to, 1);
        chk("to_div_stable", div_bad, 0);
        chk("to_div_after", spi_clk_div, 8'd4);

        // CMD8 final frame byte 0x87 (computed or supplied CRC)
        prep(8'd200);
        poll_resp[0] = 8'h01; poll_len = 1;
`ifdef SD_CMD_CRC7_EN
        start_cmd(6'd8, 32'h0000_01AA, 7'h00, 1'b0);
`else
        start_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b0);
`endif
        wait_done("cmd8");
        chk("cmd8_len", mosi_q.size(), 7);
        chk("cmd8_b0", (mosi_q.size() > 0) ? mosi_q[0] : 8'hxx, 8'h48);
        chk("cmd8_b4", (mosi_q.size() > 4) ? mosi_q[4] : 8'hxx, 8'hAA);
        chk("cmd8_crc", (mosi_q.size() > 5) ? mosi_q[5] : 8'hxx, 8'h87);
        chk("cmd8_resp", done_resp, 8'h01);
        chk("cmd8_to", done_to, 0);

        // Second start while busy is ignored
        prep(8'd200);
        poll_resp[0] = 8'h00; poll_len = 1;
        start_cmd(6'd0, 32'h0, 7'h4A, 1'b0);
        k = 0;
        while (mosi_q.size() < 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        cmd_index = 6'd17;
        cmd_arg   = 32'hDEAD_BEEF;
        cmd_start = 1'b1;
        repeat (3) @(negedge clk);
        cmd_start = 1'b0;
        wait_done("dbl");
        chk("dbl_len", mosi_q.size(), 7);
        chk("dbl_b0", (mosi_q.size() > 0) ? mosi_q[0] : 8'hxx, 8'h40);
        chk("dbl_b1", (mosi_q.size() > 1) ? mosi_q[1] : 8'hxx, 8'h00);
        chk("dbl_resp", done_resp, 8'h00);

        // Reset during byte 3 of a fast command, then a normal CMD0
        prep(8'd4);
        start_cmd(6'd0, 32'h0, 7'h4A, 1'b1);
        k = 0;
        while (mosi_q.size() < 4 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reached_b3", mosi_q.size(), 4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_busy", cmd_busy, 0);
        chk("mid_done", cmd_done, 0);
        chk("mid_resp", resp_r1, 8'hFF);
        chk("mid_to", resp_timeout, 0);
        chk("mid_wr", spi_write_en, 0);
        chk("mid_rd", spi_read_en, 0);
        chk("mid_dw", spi_data_write, 8'hFF);
        chk("mid_div", spi_clk_div, 8'd200);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        prep(8'd200);
        poll_resp[0] = 8'hFF; poll_resp[1] = 8'hFF; poll_resp[2] = 8'h01; poll_len = 3;
        start_cmd(6'd0, 32'h0, 7'h4A, 1'b0);
        wait_done("post");
        chk_mosi("post", exp_cmd0, 9);
        chk("post_resp", done_resp, 8'h01);
        chk("post_to", done_to, 0);
        chk("rw_together", rw_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
